// File: rtl/avalon_st_arbiter_if.sv
// avalon_st_arbiter_if: per-source Avalon-ST inputs and the shared sink port of the arbiter
interface avalon_st_arbiter_if #(
    parameter int NUM_SRC = 3,
    parameter int DATA_W  = 8
);
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic [1:0]                out_channel;
    logic                      busy;
    modport master (
        input  src_valid, src_data, out_ready,
        output src_ready, out_valid, out_data, out_channel, busy
    );
    modport slave (
        output src_valid, src_data, out_ready,
        input  src_ready, out_valid, out_data, out_channel, busy
    );
endinterface

// File: rtl/avalon_st_arbiter.sv
// avalon_st_arbiter: burst arbiter sharing one Avalon-ST sink, round-robin or fixed priority via AVALON_ARB_FIXED_PRIO_EN
module avalon_st_arbiter #(
    parameter int NUM_SRC   = 3,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input logic clk,
    input logic reset,
    avalon_st_arbiter_if.master bus
);
    localparam int GW = $clog2(NUM_SRC);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d, last_grant_q, last_grant_d, pick;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_channel_q, out_channel_d;
    logic              free, req, accept;
    assign free   = ~out_valid_q | bus.out_ready;
    assign req    = bus.src_valid[grant_q];
    assign accept = (state_q == GRANT) & req & free;
    assign bus.src_ready   = (state_q == GRANT && free) ? NUM_SRC'(1) << grant_q : '0;
    assign bus.busy        = state_q == GRANT;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_channel = out_channel_q;
    // choose the next source: lowest index, or first requester after the last grant
    always_comb begin
        pick = last_grant_q;
`ifdef AVALON_ARB_FIXED_PRIO_EN
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (bus.src_valid[i]) pick = GW'(i);
`else
        for (int k = NUM_SRC; k >= 1; k--)
            for (int i = 0; i < NUM_SRC; i++)
                if (bus.src_valid[i] && i == (int'(last_grant_q) + k) % NUM_SRC) pick = GW'(i);
`endif
    end
    // grant FSM next state and output register next values
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        beat_cnt_d    = accept ? beat_cnt_q + 4'd1 : beat_cnt_q;
        out_valid_d   = accept | (out_valid_q & ~bus.out_ready);
        out_data_d    = accept ? bus.src_data[grant_q*DATA_W +: DATA_W] : out_data_q;
        out_channel_d = accept ? 2'(grant_q) : out_channel_q;
        if (state_q == IDLE) begin
            if (|bus.src_valid) begin
                grant_d    = pick;
                beat_cnt_d = '0;
                state_d    = GRANT;
            end
        end else if (!req || (accept && beat_cnt_q == 4'(MAX_BURST - 1))) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
        end
    end
    // state and output registers; reset restarts arbitration at source 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= GW'(NUM_SRC - 1);
            beat_cnt_q    <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            beat_cnt_q    <= beat_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
        end
    end
endmodule

// File: tb/tb_avalon_st_arbiter.sv
// tb_avalon_st_arbiter: vector table, directed corner cases and random traffic against a reference model
module tb_avalon_st_arbiter;
    localparam int N = 3;
    localparam int W = 8;
    localparam int MB = 4;
`ifdef AVALON_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    avalon_st_arbiter_if #(.NUM_SRC(N), .DATA_W(W)) bus();
    avalon_st_arbiter #(.NUM_SRC(N), .DATA_W(W), .MAX_BURST(MB)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [N-1:0] vin;
        logic         rdy;
        logic         ov;
        logic         busy;
        logic [1:0]   ch;
        logic [7:0]   data;
    } vec_t;
    vec_t tbl[18];

    int tests = 0;
    int fails = 0;
    logic [W-1:0] sq[N][$];
    logic [W-1:0] cd[N];
    logic [N-1:0] en, cv;
    logic ordy, cr;
    int rx[$];
    int exp_rx[$];
    bit m_busy, m_ov;
    int m_owner, m_left, m_last, m_och;
    logic [W-1:0] m_od;
    int e_ov[10]   = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 0};
    int e_busy[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    int e_data[10] = '{0, 0, 'h10, 'h11, 'h12, 'h13, 'h13, 'h14, 'h15, 'h15};

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(logic ov, logic busy, logic [1:0] ch, logic [7:0] data);
        vec_t v;
        v.vin = '1;
        v.rdy = 1'b1;
        v.ov = ov;
        v.busy = busy;
        v.ch = ch;
        v.data = data;
        return v;
    endfunction

    function automatic int pick(logic [N-1:0] v);
        int p = 0;
        if (FP) begin
            for (int i = N - 1; i >= 0; i--) if (v[i]) p = i;
        end else begin
            for (int k = N; k >= 1; k--) if (v[(m_last + k) % N]) p = (m_last + k) % N;
        end
        return p;
    endfunction

    task automatic drive();
        logic [N*W-1:0] d = '0;
        for (int i = 0; i < N; i++) begin
            cv[i] = en[i] && sq[i].size() > 0;
            cd[i] = sq[i].size() > 0 ? sq[i][0] : '0;
            d[i*W +: W] = cd[i];
        end
        cr = ordy;
        bus.src_valid = cv;
        bus.src_data = d;
        bus.out_ready = cr;
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_ov = 0;
        m_owner = 0;
        m_left = 0;
        m_last = N - 1;
        m_od = '0;
        m_och = 0;
    endtask

    task automatic sample();
        @(negedge clk);
        check("out_valid", bus.out_valid, m_ov);
        check("out_data", bus.out_data, m_od);
        check("out_channel", bus.out_channel, m_och);
        check("busy", bus.busy, m_busy);
        check("src_ready", bus.src_ready, (m_busy && (!m_ov || cr)) ? 1 << m_owner : 0);
    endtask

    task automatic tick();
        bit acc;
        @(posedge clk);
        if (reset) model_reset();
        else begin
            acc = m_busy && cv[m_owner] && (!m_ov || cr);
            if (m_ov && cr) m_ov = 0;
            if (acc) begin
                m_ov = 1;
                m_od = cd[m_owner];
                m_och = m_owner;
                void'(sq[m_owner].pop_front());
                m_left--;
            end
            if (m_busy) begin
                if (!cv[m_owner] || (acc && m_left == 0)) begin
                    m_busy = 0;
                    m_last = m_owner;
                end
            end else if (|cv) begin
                m_owner = pick(cv);
                m_busy = 1;
                m_left = MB;
            end
        end
        #1 drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear();
        for (int i = 0; i < N; i++) sq[i].delete();
        en = '0;
        ordy = 1'b1;
        rx.delete();
        exp_rx.delete();
        drive();
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 0, 8'h00);
        tbl[1]  = mk(0, 1, 0, 8'h00);
        tbl[2]  = mk(1, 1, 0, 8'hA0);
        tbl[3]  = mk(1, 1, 0, 8'hA0);
        tbl[4]  = mk(1, 1, 0, 8'hA0);
        tbl[5]  = mk(1, 0, 0, 8'hA0);
        tbl[6]  = mk(0, 1, 0, 8'hA0);
        tbl[7]  = mk(1, 1, 1, 8'hA1);
        tbl[8]  = mk(1, 1, 1, 8'hA1);
        tbl[9]  = mk(1, 1, 1, 8'hA1);
        tbl[10] = mk(1, 0, 1, 8'hA1);
        tbl[11] = mk(0, 1, 1, 8'hA1);
        tbl[12] = mk(1, 1, 2, 8'hA2);
        tbl[13] = mk(1, 1, 2, 8'hA2);
        tbl[14] = mk(1, 1, 2, 8'hA2);
        tbl[15] = mk(1, 0, 2, 8'hA2);
        tbl[16] = mk(0, 1, 2, 8'hA2);
        tbl[17] = mk(1, 1, 0, 8'hA0);
        model_reset();
        clear();
        do_reset();

        sample();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_channel", bus.out_channel, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_src_ready", bus.src_ready, 0);
        tick();

        for (int i = 0; i < 6; i++) sq[0].push_back(8'(8'h10 + i));
        en = 3'b001;
        drive();
        for (int k = 0; k < 10; k++) begin
            sample();
            check($sformatf("single_ov%0d", k), bus.out_valid, e_ov[k]);
            check($sformatf("single_busy%0d", k), bus.busy, e_busy[k]);
            check($sformatf("single_data%0d", k), bus.out_data, e_data[k]);
            check($sformatf("single_ch%0d", k), bus.out_channel, 0);
            tick();
        end

        clear();
        do_reset();
        for (int i = 0; i < N; i++) for (int j = 0; j < 30; j++) sq[i].push_back(8'(8'hA0 + i));
        for (int k = 0; k < 18; k++) begin
            en = tbl[k].vin;
            ordy = tbl[k].rdy;
            drive();
            sample();
            check($sformatf("tbl_ov%0d", k), bus.out_valid, tbl[k].ov);
            check($sformatf("tbl_busy%0d", k), bus.busy, tbl[k].busy);
            check($sformatf("tbl_ch%0d", k), bus.out_channel, FP ? 2'd0 : tbl[k].ch);
            check($sformatf("tbl_data%0d", k), bus.out_data, (FP && tbl[k].data != 0) ? 8'hA0 : tbl[k].data);
            tick();
        end

        clear();
        do_reset();
        for (int i = 0; i < 4; i++) sq[1].push_back(8'(8'h20 + i));
        en = 3'b010;
        drive();
        for (int k = 0; k < 12; k++) begin
            sample();
            if (k >= 2 && k <= 4) begin
                check("bp_hold_data", bus.out_data, 8'h20);
                check("bp_hold_ch", bus.out_channel, 1);
                check("bp_ready", bus.src_ready[1], 0);
            end
            if (bus.out_valid && cr) rx.push_back(int'(bus.out_data));
            ordy = !(k + 1 >= 2 && k + 1 <= 4);
            tick();
        end
        check("bp_count", rx.size(), 4);
        for (int i = 0; i < 4 && i < rx.size(); i++) check($sformatf("bp_beat%0d", i), rx[i], 8'h20 + i);

        clear();
        do_reset();
        sq[2].push_back(8'h30);
        sq[2].push_back(8'h31);
        en = 3'b100;
        drive();
        exp_rx = '{'h230, 'h231, 'h040, 'h041, 'h042, 'h043, 'h044, 'h045};
        for (int k = 0; k < 15; k++) begin
            sample();
            if (k == 4 || k == 9) check($sformatf("early_busy%0d", k), bus.busy, 0);
            if (bus.out_valid && cr) rx.push_back(int'({bus.out_channel, bus.out_data}));
            if (k == 0) begin
                for (int i = 0; i < 6; i++) sq[0].push_back(8'(8'h40 + i));
                en = 3'b101;
            end
            tick();
        end
        check("early_count", rx.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size() && i < rx.size(); i++) check($sformatf("early_beat%0d", i), rx[i], exp_rx[i]);

        clear();
        do_reset();
        for (int i = 0; i < 4; i++) sq[1].push_back(8'(8'h50 + i));
        en = 3'b010;
        drive();
        for (int k = 0; k < 3; k++) begin
            sample();
            if (k < 2) tick();
        end
        check("mid_out_valid", bus.out_valid, 1);
        reset = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_src_ready", bus.src_ready, 0);
        check("arst_busy", bus.busy, 0);
        sq[0].push_back(8'h60);
        sq[0].push_back(8'h61);
        en = 3'b011;
        do_reset();
        sample();
        check("post_rst_idle", bus.busy, 0);
        tick();
        sample();
        check("post_rst_ready", bus.src_ready, 3'b001);
        tick();
        sample();
        check("post_rst_ch", bus.out_channel, 0);
        check("post_rst_data", bus.out_data, 8'h60);
        tick();

        clear();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            sample();
            en = N'($urandom);
            ordy = $urandom_range(0, 3) != 0;
            for (int i = 0; i < N; i++) while (sq[i].size() < 3) sq[i].push_back(8'($urandom));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/avalon_st_arbiter.md
Name: avalon_st_arbiter

Overview:
- Round-robin arbiter that shares one Avalon-ST sink between NUM_SRC Avalon-ST sources.
- Grants one source at a time for a burst of up to MAX_BURST beats, forwards its beats through a single output register, and tags each beat with the source index.
- Sits between the per-channel stream generators and the shared downstream consumer. Uses readyLatency 0 on all ports.

Parameters:
- NUM_SRC, 3, number of sources; legal range 2..4.
- DATA_W, 8, data width per source.
- MAX_BURST, 4, maximum beats per grant; legal range 1..15.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- src_valid  input  NUM_SRC  per-source valid.
- src_ready  output  NUM_SRC  per-source ready; combinational, at most one bit high.
- src_data  input  NUM_SRC*DATA_W  flat bus; source i occupies bits [i*DATA_W +: DATA_W].
- out_valid  output  1  sink valid (registered).
- out_ready  input  1  sink ready.
- out_data  output  DATA_W  sink data (registered).
- out_channel  output  2  index of the source that produced the current out_data (registered).
- busy  output  1  high while state is GRANT.

Behaviour:
- Reset (async, reset=1):
  - state=IDLE, grant=0, beat_cnt=0, last_grant=NUM_SRC-1 (source 0 wins first).
  - out_valid=0, out_data=0, out_channel=0, busy=0.
  - src_ready=0 while reset is high.
- Output register:
  - Free when ~out_valid | out_ready.
  - accept = src_valid[grant] & src_ready[grant].
  - On accept: out_data<=src_data[grant], out_channel<=grant, out_valid<=1.
  - Else if out_ready: out_valid<=0.
  - While out_valid=1 and out_ready=0, out_data and out_channel hold.
  - Full throughput is 1 beat/clk under continuous out_ready.
- State machine:
  - IDLE:
    - src_ready=0.
    - If any src_valid: pick the first set bit scanning last_grant+1, last_grant+2, ... modulo NUM_SRC. Register it to grant, beat_cnt<=0, go to GRANT.
    - No request: stay in IDLE.
  - GRANT:
    - src_ready[grant] = ~out_valid | out_ready; all other bits 0.
    - On accept: beat_cnt++.
    - If accept and beat_cnt==MAX_BURST-1: last_grant<=grant, go to IDLE.
    - If src_valid[grant]=0: early release. No beat that cycle; last_grant<=grant, go to IDLE.
    - src_valid[grant]=1 with backpressure (not free): stay in GRANT, counter unchanged.
- Latency:
  - Request seen in IDLE at cycle N. Grant is registered at edge N+1. The first beat is accepted in cycle N+1, and out_valid is high from cycle N+2.
  - One idle cycle between consecutive grants (arbitration bubble). This is required behaviour, not a defect.
- Boundary conditions:
  - A sole active source is regranted after each burst, with the one-cycle bubble.
  - MAX_BURST=1 gives per-beat round-robin.
  - A valid asserted by a non-granted source mid-burst is ignored until the next IDLE.
  - Reset mid-burst drops the in-flight out beat and restarts from source 0.
  - The output register keeps draining while in IDLE.
  - out_channel is zero-extended when NUM_SRC<=2.

Optional Feature:
- Macro AVALON_ARB_FIXED_PRIO_EN.
- Defined: IDLE selection is fixed priority, where the lowest set src_valid index wins. last_grant is ignored. Burst limit and early release are unchanged, so MAX_BURST still bounds starvation per grant.
- Undefined: round-robin as specified above.

Test Plan:
- Single source, NUM_SRC=3, MAX_BURST=4, src0 streams 6 beats 0x10..0x15, out_ready=1 -> out_data 0x10..0x13 on consecutive cycles (ch 0), one bubble cycle, then 0x14,0x15 (ch 0). busy low during the bubble.
- All three sources continuously valid, out_ready=1 -> out_channel sequence 0,0,0,0,1,1,1,1,2,2,2,2,0,..., each group of 4 separated by one bubble cycle.
- Backpressure: src1 granted, out_ready=0 for 3 cycles after the first beat -> out_data and out_channel hold, src_ready[1]=0. After out_ready=1, beats resume with none lost or duplicated.
- Early release: src2 drops valid after 2 beats while src0 is requesting -> src2 grant ends after 2 beats, then bubble, then src0 granted; src2's beat_cnt does not carry over.
- Reset asserted mid-burst (out_valid=1) -> out_valid=0, src_ready=0 immediately. After release with src1 and src0 requesting, src0 is granted first.
- With AVALON_ARB_FIXED_PRIO_EN, src0 and src2 continuously valid -> only ch 0 bursts of 4 separated by bubbles. src2 is served only when src0 is idle.
